// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash read engine: opcodes,
// gap timing and FSM state encoding.
package flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_FAST = 8'h0B;
    localparam logic [7:0] OP_WAKE = 8'hAB;

    // ce ticks with cs high after release-from-power-down (tRES1 margin)
    localparam int WGAP_TICKS = 64;
    // ce ticks with cs high before done is reported
    localparam int END_TICKS  = 2;
    // gap counter width, wide enough for WGAP_TICKS
    localparam int GCW        = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAKE,
        S_WGAP,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_HOLD,
        S_END
    } state_t;

endpackage

// File: rtl/spi_shift.sv
// SPI mode-0 byte shifter: one ce tick per SCK half period, MSB first.
// Ports: clock/reset; tick (ce), run (toggle ck), load/din (new byte,
// ck low, bit count cleared); miso in; ck/mosi out; rx_byte (byte being
// completed on this rise); rise_last (8th rise now); byte_end (fall
// after the 8th rise, the point where the next byte may be loaded).
module spi_shift (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       miso,
    output logic       ck,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       rise_last,
    output logic       byte_end
);

    logic       ck_q, ck_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] rx_q, rx_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        ck_d  = ck_q;
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (load) begin
            // load also serves as the falling edge of the previous byte
            tx_d  = din;
            cnt_d = 4'd0;
            ck_d  = 1'b0;
        end else if (tick && run) begin
            if (!ck_q) begin
                ck_d  = 1'b1;
                rx_d  = {rx_q[5:0], miso};
                cnt_d = cnt_q + 4'd1;
            end else begin
                ck_d = 1'b0;
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ck_q  <= 1'b0;
            tx_q  <= 8'h00;
            rx_q  <= 7'h00;
            cnt_q <= 4'd0;
        end else begin
            ck_q  <= ck_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

    assign ck        = ck_q;
    assign mosi      = tx_q[7];
    assign rx_byte   = {rx_q, miso};
    assign rise_last = tick && run && !ck_q && (cnt_q == 4'd7);
    assign byte_end  = tick && run && ck_q && (cnt_q == 4'd8);

endmodule

// File: rtl/flash_read.sv
// SPI NOR flash read engine (0x03 / 0x0B with dummy, optional wake).
// Ports: clock/reset (sync, high); ce (SCK half-period tick); start,
// fast, addr, len (latched on accept); busy, done; q/qstb/rdy byte
// stream; cs (active low), ck, mosi, miso flash pins.
module flash_read
    import flash_pkg::*;
#(
    parameter int AW   = 24,
    parameter int LW   = 8,
    parameter int WAKE = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          start,
    input  logic          fast,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [7:0]    q,
    output logic          qstb,
    input  logic          rdy,
    output logic          cs,
    output logic          ck,
    output logic          mosi,
    input  logic          miso
);

    localparam int NAB = AW / 8;
    localparam int ACW = $clog2(NAB + 1);

    state_t          state_q, state_d;
    logic            cs_q, cs_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            qstb_q, qstb_d;
    logic [7:0]      q_q, q_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic            fast_q, fast_d;
    logic [ACW-1:0]  acnt_q, acnt_d;
    logic [GCW-1:0]  gcnt_q, gcnt_d;

    logic       run;
    logic       load;
    logic [7:0] ld_byte;
    logic [7:0] rx_byte;
    logic       rise_last;
    logic       byte_end;

    // ck only toggles while selected inside a byte-shifting state
    assign run = !cs_q && (state_q inside
        {S_WAKE, S_CMD, S_ADDR, S_DUMMY, S_DATA});

    spi_shift u_shift (
        .clock     (clock),
        .reset     (reset),
        .tick      (ce),
        .run       (run),
        .load      (load),
        .din       (ld_byte),
        .miso      (miso),
        .ck        (ck),
        .mosi      (mosi),
        .rx_byte   (rx_byte),
        .rise_last (rise_last),
        .byte_end  (byte_end)
    );

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        qstb_d  = 1'b0;
        q_d     = q_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        fast_d  = fast_q;
        acnt_d  = acnt_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        ld_byte = 8'h00;

        if (state_q == S_DATA && rise_last) begin
            q_d    = rx_byte;
            qstb_d = 1'b1;
            rem_d  = rem_q - LW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                // done_q blocks a start on the clock done is pulsing
                if (start && !done_q) begin
                    addr_d  = addr;
                    rem_d   = len;
                    fast_d  = fast;
                    busy_d  = 1'b1;
                    state_d = (WAKE != 0) ? S_WAKE : S_CMD;
                end
            end
            S_WAKE: begin
                if (ce && cs_q) begin
                    cs_d    = 1'b0;
                    load    = 1'b1;
                    ld_byte = OP_WAKE;
                end else if (byte_end) begin
                    state_d = S_WGAP;
                end
            end
            S_WGAP: begin
                if (ce) begin
                    if (!cs_q) begin
                        cs_d   = 1'b1;
                        gcnt_d = '0;
                    end else if (gcnt_q == GCW'(WGAP_TICKS - 1)) begin
                        state_d = S_CMD;
                    end else begin
                        gcnt_d = gcnt_q + GCW'(1);
                    end
                end
            end
            S_CMD: begin
                // first tick only drops cs; ck rises on the next one
                if (ce && cs_q) begin
                    cs_d    = 1'b0;
                    load    = 1'b1;
                    ld_byte = fast_q ? OP_FAST : OP_READ;
                end else if (byte_end) begin
                    load    = 1'b1;
                    ld_byte = addr_q[AW-1 -: 8];
                    addr_d  = addr_q << 8;
                    acnt_d  = ACW'(NAB - 1);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (byte_end) begin
                    load = 1'b1;
                    if (acnt_q != '0) begin
                        ld_byte = addr_q[AW-1 -: 8];
                        addr_d  = addr_q << 8;
                        acnt_d  = acnt_q - ACW'(1);
                    end else begin
                        state_d = fast_q ? S_DUMMY : S_DATA;
                    end
                end
            end
            S_DUMMY: begin
                if (byte_end) begin
                    load    = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // rem_q was already decremented on this byte's last rise
                if (byte_end) begin
                    if (rem_q == '0) begin
                        state_d = S_END;
                    end else if (rdy) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (ce && rdy) begin
                    load    = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_END: begin
                if (ce) begin
                    if (!cs_q) begin
                        cs_d   = 1'b1;
                        gcnt_d = '0;
                    end else if (gcnt_q == GCW'(END_TICKS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gcnt_d = gcnt_q + GCW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            qstb_q  <= 1'b0;
            q_q     <= 8'h00;
            addr_q  <= '0;
            rem_q   <= '0;
            fast_q  <= 1'b0;
            acnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            qstb_q  <= qstb_d;
            q_q     <= q_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            fast_q  <= fast_d;
            acnt_q  <= acnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign qstb = qstb_q;
    assign q    = q_q;
    assign cs   = cs_q;

endmodule

// File: tb/tb_flash_read.sv
// Bench for flash_read: behavioural SPI flash model, ce every 4th clock,
// randomized reads plus directed stall, wake, abort and start-hold cases.
module tb_flash_read;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        fast_i = 1'b0;
    logic        rdy = 1'b1;
    logic [23:0] addr_i = 24'h0;
    logic [7:0]  len0 = 8'h0;
    logic [3:0]  len1 = 4'h0;
    logic        miso = 1'b0;

    logic        busy0, done0, qstb0, cs0, ck0, mosi0;
    logic [7:0]  q0;
    logic        busy1, done1, qstb1, cs1, ck1, mosi1;
    logic [7:0]  q1;

    bit          sel = 1'b0;
    logic        m_cs, m_ck, m_mosi, qstb_m, done_m;
    logic [7:0]  q_m;

    int vec = 0;
    int miss = 0;

    always #5 clock = ~clock;

    flash_read #(.AW(24), .LW(8), .WAKE(0)) u0 (
        .clock(clock), .reset(reset), .ce(ce), .start(start0),
        .fast(fast_i), .addr(addr_i), .len(len0), .busy(busy0),
        .done(done0), .q(q0), .qstb(qstb0), .rdy(rdy),
        .cs(cs0), .ck(ck0), .mosi(mosi0), .miso(miso)
    );

    flash_read #(.AW(24), .LW(4), .WAKE(1)) u1 (
        .clock(clock), .reset(reset), .ce(ce), .start(start1),
        .fast(fast_i), .addr(addr_i), .len(len1), .busy(busy1),
        .done(done1), .q(q1), .qstb(qstb1), .rdy(rdy),
        .cs(cs1), .ck(ck1), .mosi(mosi1), .miso(miso)
    );

    assign m_cs   = sel ? cs1 : cs0;
    assign m_ck   = sel ? ck1 : ck0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign qstb_m = sel ? qstb1 : qstb0;
    assign done_m = sel ? done1 : done0;
    assign q_m    = sel ? q1 : q0;

    // ---------------- flash model ----------------
    logic [7:0]  mem [256];
    logic [7:0]  rxsh = 8'h0;
    logic [23:0] taddr = 24'h0;
    int bitc = 0, bytes_done = 0, nhdr = 1000;
    int sck_cnt = 0, midbyte = 0, idx = 0;
    logic [7:0] mlog[$];
    logic [7:0] qlog[$];
    logic [7:0] emlog[$];
    logic [7:0] eqlog[$];
    int done_cnt = 0;
    int gap = 0, last_gap = 0;
    logic prev_cs = 1'b1;
    int cediv = 0;

    always @(negedge m_cs) begin
        bitc = 0;
        bytes_done = 0;
        nhdr = 1000;
    end

    always @(posedge m_cs) begin
        if (bitc != 0) midbyte++;
    end

    always @(posedge m_ck) begin
        sck_cnt++;
        if (!m_cs) begin
            rxsh = {rxsh[6:0], m_mosi};
            bitc++;
            if (bitc == 8) begin
                bitc = 0;
                mlog.push_back(rxsh);
                if (bytes_done == 0)
                    nhdr = (rxsh == 8'h0B) ? 5 : (rxsh == 8'h03) ? 4 : 1000;
                else if (bytes_done <= 3)
                    taddr = {taddr[15:0], rxsh};
                bytes_done++;
            end
        end
    end

    // data bits change on falling ck; header/dummy time gets noise
    always @(negedge m_ck) begin
        if (!m_cs && bytes_done >= nhdr) begin
            idx = (int'(taddr[7:0]) + bytes_done - nhdr) % 256;
            miso = mem[idx][7-bitc];
        end else begin
            miso = 1'($urandom);
        end
    end

    always @(negedge clock) begin
        cediv = (cediv == 3) ? 0 : cediv + 1;
        ce = (cediv == 0);
    end

    always @(posedge clock) begin
        #1;
        if (qstb_m) qlog.push_back(q_m);
        if (done_m) done_cnt++;
        if (m_cs) begin
            if (!prev_cs) gap = 0;
            if (ce) gap++;
        end else if (prev_cs) begin
            last_gap = gap;
        end
        prev_cs = m_cs;
    end

    // ---------------- helpers ----------------
    function automatic int qdiff(input logic [7:0] x[$], input logic [7:0] y[$]);
        if (x.size() != y.size()) return -2;
        foreach (x[i]) if (x[i] !== y[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        mlog.delete();
        qlog.delete();
        emlog.delete();
        eqlog.delete();
        done_cnt = 0;
        sck_cnt = 0;
        midbyte = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // expected pin traffic and byte stream for one read
    task automatic model_xfer(input bit wk, input logic [23:0] a,
                              input bit f, input int n);
        if (wk) emlog.push_back(8'hAB);
        emlog.push_back(f ? 8'h0B : 8'h03);
        emlog.push_back(a[23:16]);
        emlog.push_back(a[15:8]);
        emlog.push_back(a[7:0]);
        if (f) emlog.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
            emlog.push_back(8'h00);
            eqlog.push_back(mem[(int'(a[7:0]) + k) % 256]);
        end
    endtask

    task automatic launch(input bit w, input logic [23:0] a,
                          input int l, input bit f);
        @(negedge clock);
        sel = w;
        addr_i = a;
        fast_i = f;
        len0 = 8'(l);
        len1 = 4'(l);
        if (w) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            if (done_m) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        vec++;
        if ({cs0, ck0, mosi0, busy0, done0, qstb0} !== 6'b100000) begin
            miss++;
            $display("FAIL reset_pins0: got %b want 100000",
                     {cs0, ck0, mosi0, busy0, done0, qstb0});
        end
        vec++;
        if (q0 !== 8'h00) begin
            miss++;
            $display("FAIL reset_q0: got %h want 00", q0);
        end
        vec++;
        if ({cs1, ck1, mosi1, busy1, done1, qstb1, q1} !== {6'b100000, 8'h00}) begin
            miss++;
            $display("FAIL reset_pins1: got %b want 10000000000000",
                     {cs1, ck1, mosi1, busy1, done1, qstb1, q1});
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_basic();
        bit to;
        int d;
        logic [7:0] want[$];
        fill_mem();
        mem[8'h4D] = 8'h02;
        clear_logs();
        launch(1'b0, 24'h00704D, 1, 1'b0);
        wait_done(to);
        vec++;
        if (to) begin
            miss++;
            $display("FAIL basic_timeout: got no done want done");
        end
        want = '{8'h03, 8'h00, 8'h70, 8'h4D, 8'h00};
        d = qdiff(mlog, want);
        vec++;
        if (d != -1) begin
            miss++;
            $display("FAIL basic_mosi: diff %0d got %0d bytes want %0d", d,
                     mlog.size(), want.size());
        end
        vec++;
        if (qlog.size() != 1 || qlog[0] !== 8'h02) begin
            miss++;
            $display("FAIL basic_q: got %0d bytes first %h want 1 byte 02",
                     qlog.size(), (qlog.size() > 0) ? qlog[0] : 8'hxx);
        end
        vec++;
        if (done_cnt != 1) begin
            miss++;
            $display("FAIL basic_done: got %0d want 1", done_cnt);
        end
        vec++;
        if (sck_cnt != 40) begin
            miss++;
            $display("FAIL basic_sck: got %0d want 40", sck_cnt);
        end
        vec++;
        if (midbyte != 0) begin
            miss++;
            $display("FAIL basic_midbyte: got %0d want 0", midbyte);
        end
    endtask

    task automatic test_fast();
        bit to;
        int d;
        logic [7:0] wq[$];
        logic [7:0] wm[$];
        fill_mem();
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        clear_logs();
        launch(1'b0, 24'h000100, 4, 1'b1);
        wait_done(to);
        vec++;
        if (to) begin
            miss++;
            $display("FAIL fast_timeout: got no done want done");
        end
        wm = '{8'h0B, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        d = qdiff(mlog, wm);
        vec++;
        if (d != -1) begin
            miss++;
            $display("FAIL fast_mosi: diff %0d got %0d bytes want %0d", d,
                     mlog.size(), wm.size());
        end
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        d = qdiff(qlog, wq);
        vec++;
        if (d != -1) begin
            miss++;
            $display("FAIL fast_q: diff %0d got %0d bytes want 4", d, qlog.size());
        end
    endtask

    task automatic test_random();
        bit to;
        int d, l;
        bit f;
        logic [23:0] a;
        for (int t = 0; t < 6; t++) begin
            fill_mem();
            clear_logs();
            l = $urandom_range(1, 5);
            f = 1'($urandom);
            a = 24'($urandom);
            model_xfer(1'b0, a, f, l);
            launch(1'b0, a, l, f);
            wait_done(to);
            d = qdiff(qlog, eqlog);
            vec++;
            if (to || d != -1) begin
                miss++;
                $display("FAIL rand_q[%0d]: diff %0d got %0d bytes want %0d to=%0d",
                         t, d, qlog.size(), eqlog.size(), to);
            end
            d = qdiff(mlog, emlog);
            vec++;
            if (d != -1 || done_cnt != 1) begin
                miss++;
                $display("FAIL rand_mosi[%0d]: diff %0d got %0d dones want 1",
                         t, d, done_cnt);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int d, bad, seen;
        logic [23:0] a;
        fill_mem();
        clear_logs();
        a = 24'($urandom);
        model_xfer(1'b0, a, 1'b0, 3);
        rdy = 1'b0;
        launch(1'b0, a, 3, 1'b0);
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (qlog.size() >= 1) begin
                seen = 1;
                break;
            end
        end
        vec++;
        if (seen == 0) begin
            miss++;
            $display("FAIL stall_first: got no byte want 1 byte");
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i >= 8 && (ck0 !== 1'b0 || cs0 !== 1'b0)) bad++;
        end
        vec++;
        if (bad != 0 || qlog.size() != 1) begin
            miss++;
            $display("FAIL stall_hold: got %0d bad clocks %0d bytes want 0 and 1",
                     bad, qlog.size());
        end
        rdy = 1'b1;
        wait_done(to);
        d = qdiff(qlog, eqlog);
        vec++;
        if (to || d != -1) begin
            miss++;
            $display("FAIL stall_q: diff %0d got %0d bytes want 3", d, qlog.size());
        end
        d = qdiff(mlog, emlog);
        vec++;
        if (d != -1 || midbyte != 0) begin
            miss++;
            $display("FAIL stall_mosi: diff %0d midbyte %0d want -1 and 0", d, midbyte);
        end
    endtask

    task automatic test_wake_len0();
        bit to;
        int d;
        logic [23:0] a;
        fill_mem();
        clear_logs();
        a = 24'($urandom);
        model_xfer(1'b1, a, 1'b0, 16);
        launch(1'b1, a, 0, 1'b0);
        wait_done(to);
        d = qdiff(qlog, eqlog);
        vec++;
        if (to || d != -1) begin
            miss++;
            $display("FAIL wake_q: diff %0d got %0d bytes want 16", d, qlog.size());
        end
        d = qdiff(mlog, emlog);
        vec++;
        if (d != -1) begin
            miss++;
            $display("FAIL wake_mosi: diff %0d got %0d bytes want %0d", d,
                     mlog.size(), emlog.size());
        end
        vec++;
        if (last_gap < 64 || last_gap > 70) begin
            miss++;
            $display("FAIL wake_gap: got %0d ticks want 64..70", last_gap);
        end
        vec++;
        if (done_cnt != 1) begin
            miss++;
            $display("FAIL wake_done: got %0d want 1", done_cnt);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit to;
        int d, hit;
        logic [23:0] a;
        fill_mem();
        clear_logs();
        launch(1'b0, 24'($urandom), 2, 1'b0);
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (bytes_done == 2 && bitc == 3) begin
                hit = 1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clock);
        vec++;
        if (hit == 0 || {cs0, ck0, busy0, mosi0, qstb0} !== 5'b10000) begin
            miss++;
            $display("FAIL abort_pins: got %b hit %0d want 10000 hit 1",
                     {cs0, ck0, busy0, mosi0, qstb0}, hit);
        end
        reset = 1'b0;
        repeat (60) @(negedge clock);
        vec++;
        if (done_cnt != 0 || qlog.size() != 0) begin
            miss++;
            $display("FAIL abort_quiet: got %0d dones %0d bytes want 0 0",
                     done_cnt, qlog.size());
        end
        clear_logs();
        a = 24'($urandom);
        model_xfer(1'b0, a, 1'b1, 2);
        launch(1'b0, a, 2, 1'b1);
        wait_done(to);
        d = qdiff(qlog, eqlog);
        vec++;
        if (to || d != -1 || qdiff(mlog, emlog) != -1) begin
            miss++;
            $display("FAIL abort_next: diff %0d got %0d bytes want 2", d, qlog.size());
        end
    endtask

    task automatic test_start_held();
        int rises, dones, since, d;
        logic prev_busy;
        logic [23:0] a;
        fill_mem();
        clear_logs();
        a = 24'($urandom);
        model_xfer(1'b0, a, 1'b0, 2);
        model_xfer(1'b0, a, 1'b0, 2);
        @(negedge clock);
        sel = 1'b0;
        addr_i = a;
        len0 = 8'd2;
        fast_i = 1'b0;
        start0 = 1'b1;
        rises = 0;
        dones = 0;
        since = -1;
        prev_busy = 1'b0;
        for (int i = 0; i < 20000 && dones < 2; i++) begin
            @(negedge clock);
            if (since >= 0) since++;
            if (busy0 && !prev_busy) begin
                rises++;
                if (since >= 0) begin
                    vec++;
                    if (since != 2) begin
                        miss++;
                        $display("FAIL held_restart: got %0d clocks want 2", since);
                    end
                end
            end
            if (done0) begin
                dones++;
                since = 0;
                vec++;
                if (busy0 !== 1'b0) begin
                    miss++;
                    $display("FAIL held_busy_at_done: got %b want 0", busy0);
                end
            end
            prev_busy = busy0;
        end
        start0 = 1'b0;
        repeat (100) @(negedge clock);
        vec++;
        if (dones != 2 || rises != 2 || done_cnt != 2) begin
            miss++;
            $display("FAIL held_count: got %0d rises %0d dones want 2 2",
                     rises, done_cnt);
        end
        d = qdiff(qlog, eqlog);
        vec++;
        if (d != -1) begin
            miss++;
            $display("FAIL held_q: diff %0d got %0d bytes want 4", d, qlog.size());
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_basic();
        test_fast();
        test_random();
        test_stall();
        test_wake_len0();
        test_reset_mid();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
